// File: rtl/cayde_alu_pkg.sv
// Shared definitions for the cayde ALU and its two-requester arbiter:
// datapath width, opcode encodings and arbiter FSM states.
package cayde_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_LAND = 3'd3;
  localparam logic [2:0] OP_LOR  = 3'd4;
  localparam logic [2:0] OP_LNOT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cayde_alu.sv
// Purely combinational cayde ALU; all arithmetic is modulo 2^XLEN and
// unassigned opcodes produce zero.
module cayde_alu
  import cayde_alu_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic a_nz_s;
  logic b_nz_s;

  assign a_nz_s = (a_i != {XLEN{1'b0}});
  assign b_nz_s = (b_i != {XLEN{1'b0}});

  // Opcode decode to result
  always_comb begin
    result_o = {XLEN{1'b0}};
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_LAND: result_o = {{(XLEN-1){1'b0}}, a_nz_s & b_nz_s};
      OP_LOR:  result_o = {{(XLEN-1){1'b0}}, a_nz_s | b_nz_s};
      OP_LNOT: result_o = {{(XLEN-1){1'b0}}, ~a_nz_s};
      default: result_o = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/cayde_alu_arbiter.sv
// Two-requester front end for a single cayde_alu: arbitrates, latches operands,
// runs IDLE->EXEC->RESP and returns a registered result per requester.
module cayde_alu_arbiter
  import cayde_alu_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [XLEN-1:0]  req0_a_i,
  input  logic [XLEN-1:0]  req0_b_i,
  output logic             req0_rsp_valid_o,
  input  logic             req0_rsp_ready_i,
  output logic [XLEN-1:0]  req0_rsp_data_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [XLEN-1:0]  req1_a_i,
  input  logic [XLEN-1:0]  req1_b_i,
  output logic             req1_rsp_valid_o,
  input  logic             req1_rsp_ready_i,
  output logic [XLEN-1:0]  req1_rsp_data_o,
  output logic             busy_o,
  output logic             grant_o,
  output logic [CNT_W-1:0] ops_done_o
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0]  rsp0_data_q, rsp0_data_d;
  logic [XLEN-1:0]  rsp1_data_q, rsp1_data_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             win_s;
  logic             rsp_take_s;
  logic [XLEN-1:0]  alu_result_s;

  cayde_alu u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result_s)
  );

  // Winner selection; with both valid, round-robin prefers the one not last granted
  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      win_s = (PRIO_FIXED != 0) ? 1'b0 : ~grant_q;
    end else if (req1_valid_i) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  assign rsp_take_s = grant_q ? (rsp1_valid_q & req1_rsp_ready_i)
                              : (rsp0_valid_q & req0_rsp_ready_i);

  // Next-state, datapath latching and handshake logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    ops_done_d   = ops_done_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          req0_ready_o = ~win_s;
          req1_ready_o = win_s;
          grant_d      = win_s;
          op_d         = win_s ? req1_op_i : req0_op_i;
          a_d          = win_s ? req1_a_i  : req0_a_i;
          b_d          = win_s ? req1_b_i  : req0_b_i;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (grant_q) begin
          rsp1_data_d  = alu_result_s;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_data_d  = alu_result_s;
          rsp0_valid_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          ops_done_d   = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b1;
      op_q         <= 3'd0;
      a_q          <= {XLEN{1'b0}};
      b_q          <= {XLEN{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= {XLEN{1'b0}};
      rsp1_data_q  <= {XLEN{1'b0}};
      ops_done_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign req0_rsp_valid_o = rsp0_valid_q;
  assign req1_rsp_valid_o = rsp1_valid_q;
  assign req0_rsp_data_o  = rsp0_data_q;
  assign req1_rsp_data_o  = rsp1_data_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign grant_o          = grant_q;
  assign ops_done_o       = ops_done_q;

endmodule

// File: tb/tb_cayde_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus;
// expected responses are queued at acceptance and checked at response handshake.
module tb_cayde_alu_arbiter;

  typedef struct packed {
    logic        req;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0v, r0rr, r1v, r1rr;
  logic [2:0]  r0op, r1op;
  logic [31:0] r0a, r0b, r1a, r1b;

  logic        a_r0rdy, a_r1rdy, a_r0rv, a_r1rv, a_busy, a_grant;
  logic [31:0] a_r0rd, a_r1rd, a_ops;
  logic        b_r0rdy, b_r1rdy, b_r0rv, b_r1rv, b_busy, b_grant;
  logic [31:0] b_r0rd, b_r1rd, b_ops;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic chk0 = 1'b1;
  logic chk1 = 1'b0;

  always #5 clk = ~clk;

  cayde_alu_arbiter #(.PRIO_FIXED(0), .CNT_W(32)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(r0v), .req0_ready_o(a_r0rdy), .req0_op_i(r0op),
    .req0_a_i(r0a), .req0_b_i(r0b), .req0_rsp_valid_o(a_r0rv),
    .req0_rsp_ready_i(r0rr), .req0_rsp_data_o(a_r0rd),
    .req1_valid_i(r1v), .req1_ready_o(a_r1rdy), .req1_op_i(r1op),
    .req1_a_i(r1a), .req1_b_i(r1b), .req1_rsp_valid_o(a_r1rv),
    .req1_rsp_ready_i(r1rr), .req1_rsp_data_o(a_r1rd),
    .busy_o(a_busy), .grant_o(a_grant), .ops_done_o(a_ops)
  );

  cayde_alu_arbiter #(.PRIO_FIXED(1), .CNT_W(32)) dut_fx (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(r0v), .req0_ready_o(b_r0rdy), .req0_op_i(r0op),
    .req0_a_i(r0a), .req0_b_i(r0b), .req0_rsp_valid_o(b_r0rv),
    .req0_rsp_ready_i(r0rr), .req0_rsp_data_o(b_r0rd),
    .req1_valid_i(r1v), .req1_ready_o(b_r1rdy), .req1_op_i(r1op),
    .req1_a_i(r1a), .req1_b_i(r1b), .req1_rsp_valid_o(b_r1rv),
    .req1_rsp_ready_i(r1rr), .req1_rsp_data_o(b_r1rd),
    .busy_o(b_busy), .grant_o(b_grant), .ops_done_o(b_ops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic score(input logic who, input logic [31:0] data, inout exp_t q[$], input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, {31'd0, 1'b1}, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_req"}, {31'd0, who}, {31'd0, e.req});
      chk({tag, "_data"}, data, e.data);
    end
  endtask

  // Scoreboard: every response handshake pops the oldest expected result
  always @(negedge clk) begin
    if (chk0 && a_r0rv && r0rr) score(1'b0, a_r0rd, q0, "rr");
    if (chk0 && a_r1rv && r1rr) score(1'b1, a_r1rd, q0, "rr");
    if (chk1 && b_r0rv && r0rr) score(1'b0, b_r0rd, q1, "fx");
    if (chk1 && b_r1rv && r1rr) score(1'b1, b_r1rd, q1, "fx");
  end

  initial begin
    rst = 1'b1; r0v = 1'b0; r1v = 1'b0; r0rr = 1'b0; r1rr = 1'b0;
    r0op = 3'd0; r1op = 3'd0; r0a = 32'd0; r0b = 32'd0; r1a = 32'd0; r1b = 32'd0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_grant", {31'd0, a_grant}, 32'd1);
    chk("rst_ops", a_ops, 32'd0);
    chk("rst_rsp_valid", {30'd0, a_r0rv, a_r1rv}, 32'd0);
    chk("rst_rsp_data", a_r0rd | a_r1rd, 32'd0);
    chk("rst_ready", {30'd0, a_r0rdy, a_r1rdy}, 32'd0);

    // ADD overflow wraps to zero, immediate rsp_ready
    r0v = 1'b1; r0op = 3'd0; r0a = 32'hFFFF_FFFF; r0b = 32'd1; r0rr = 1'b1; r1rr = 1'b1;
    #1;
    chk("add_ready_N", {31'd0, a_r0rdy}, 32'd1);
    q0.push_back('{req: 1'b0, data: 32'h0});
    step();
    r0v = 1'b0; r0a = 32'h5555_5555;
    chk("add_busy_N1", {31'd0, a_busy}, 32'd1);
    chk("add_rv_N1", {31'd0, a_r0rv}, 32'd0);
    step();
    chk("add_rv_N2", {31'd0, a_r0rv}, 32'd1);
    chk("add_data_N2", a_r0rd, 32'h0);
    step();
    chk("add_ops_N3", a_ops, 32'd1);
    chk("add_idle_N3", {31'd0, a_busy}, 32'd0);

    // Both valid after reset: req0 first, then req1
    rst = 1'b1; step(); rst = 1'b0;
    r0v = 1'b1; r0op = 3'd1; r0a = 32'd5; r0b = 32'd7;
    r1v = 1'b1; r1op = 3'd2; r1a = 32'hF0F0_F0F0; r1b = 32'h0FF0_0FF0;
    #1;
    chk("rr_first_r0", {30'd0, a_r0rdy, a_r1rdy}, 32'd2);
    q0.push_back('{req: 1'b0, data: 32'hFFFF_FFFE});
    step();
    r0v = 1'b0;
    chk("rr_grant0", {31'd0, a_grant}, 32'd0);
    chk("rr_r1_wait", {31'd0, a_r1rdy}, 32'd0);
    step();
    chk("rr_r1_rv_quiet", {31'd0, a_r1rv}, 32'd0);
    step();
    chk("rr_second_r1", {30'd0, a_r0rdy, a_r1rdy}, 32'd1);
    q0.push_back('{req: 1'b1, data: 32'hFF00_FF00});
    step();
    r1v = 1'b0;
    chk("rr_grant1", {31'd0, a_grant}, 32'd1);
    step(); step();
    chk("rr_r0_data_hold", a_r0rd, 32'hFFFF_FFFE);
    chk("rr_ops", a_ops, 32'd2);

    // Response backpressure on req1, req0 blocked while busy
    r1v = 1'b1; r1op = 3'd3; r1a = 32'd3; r1b = 32'd0; r1rr = 1'b0;
    #1;
    chk("bp_accept", {31'd0, a_r1rdy}, 32'd1);
    q0.push_back('{req: 1'b1, data: 32'h0});
    step();
    r1v = 1'b0; r0v = 1'b1; r0op = 3'd0; r0a = 32'd9; r0b = 32'd9;
    #1;
    chk("bp_r0_blocked_exec", {31'd0, a_r0rdy}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_rv_held", {31'd0, a_r1rv}, 32'd1);
      chk("bp_data_stable", a_r1rd, 32'd0);
      chk("bp_r0_blocked", {31'd0, a_r0rdy}, 32'd0);
      step();
    end
    r0v = 1'b0; r1rr = 1'b1;
    step();
    chk("bp_done_rv", {31'd0, a_r1rv}, 32'd0);
    chk("bp_ops", a_ops, 32'd3);

    // Reset while a result is pending in RESP
    r0v = 1'b1; r0op = 3'd0; r0a = 32'd1; r0b = 32'd2; r0rr = 1'b0;
    step();
    r0v = 1'b0;
    step();
    chk("rst_resp_pending", {31'd0, a_r0rv}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_resp_rv", {31'd0, a_r0rv}, 32'd0);
    chk("rst_resp_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_resp_ops", a_ops, 32'd0);
    r0rr = 1'b1;
    r1v = 1'b1; r1op = 3'd5; r1a = 32'd0; r1b = 32'd77;
    #1;
    chk("lnot_accept", {31'd0, a_r1rdy}, 32'd1);
    q0.push_back('{req: 1'b1, data: 32'h1});
    step();
    r1v = 1'b0;
    step(); step();
    chk("lnot_ops", a_ops, 32'd1);

    // Unassigned opcode is accepted and yields zero
    r0v = 1'b1; r0op = 3'd7; r0a = 32'h1234; r0b = 32'h1234;
    #1;
    chk("op7_accept", {31'd0, a_r0rdy}, 32'd1);
    q0.push_back('{req: 1'b0, data: 32'h0});
    step();
    r0v = 1'b0;
    step(); step();
    chk("op7_ops", a_ops, 32'd2);
    chk("rr_queue_drained", q0.size(), 32'd0);

    // Fixed priority: req0 wins every contention
    chk0 = 1'b0; chk1 = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    r0v = 1'b1; r0op = 3'd0; r0a = 32'd1; r0b = 32'd1;
    r1v = 1'b1; r1op = 3'd4; r1a = 32'd0; r1b = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fx_ready", {30'd0, b_r0rdy, b_r1rdy}, 32'd2);
      q1.push_back('{req: 1'b0, data: 32'd2});
      step();
      chk("fx_grant", {31'd0, b_grant}, 32'd0);
      step(); step();
    end
    r0v = 1'b0; r1v = 1'b0;
    chk("fx_ops", b_ops, 32'd3);
    chk("fx_r1_never", {31'd0, b_r1rv}, 32'd0);
    chk("fx_queue_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cayde_alu_arbiter.md
Name: cayde_alu_arbiter

Overview:
- Shares one combinational cayde_alu instance between two requesters (e.g. decode/issue port and a debug/microcode port).
- Arbitrates between the requesters and latches their operands.
- Sequences a 3-state accept/execute/respond FSM and returns a registered result over a per-requester valid/ready response channel.
- Maintains a completed-operation counter for performance monitoring.

Parameters:
- PRIO_FIXED, 0: 0 = round-robin between req0/req1; 1 = req0 always wins ties.
- CNT_W, 32: width of ops_done_o counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_op_i  in  3  ALU opcode
- req0_a_i  in  32  operand A
- req0_b_i  in  32  operand B
- req0_rsp_valid_o  out  1  result for requester 0 available
- req0_rsp_ready_i  in  1  requester 0 takes result
- req0_rsp_data_o  out  32  result
- req1_* (same 8 ports, same widths/directions, for requester 1)
- busy_o  out  1  FSM not in IDLE
- grant_o  out  1  requester owning current/last transaction (0/1)
- ops_done_o  out  CNT_W  count of completed response handshakes

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; all *_ready_o=0, *_rsp_valid_o=0, *_rsp_data_o=0, busy_o=0.
  - grant_o=1, so round-robin favours req0 first; ops_done_o=0.
  - Latched op/operands cleared to 0.
  - Any in-flight transaction is dropped with no response.
- FSM states IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqX_ready_o is combinational: high only for the arbitration winner, only while in IDLE and reqX_valid_i=1.
  - Winner selection: if only one valid, that one. If both valid and PRIO_FIXED=0, the requester != grant_o. If both valid and PRIO_FIXED=1, req0.
  - On handshake: latch op/a/b, grant_o<=winner, go EXEC.
  - No valid: stay in IDLE.
- EXEC: latched operands drive cayde_alu; result registered into winner's rsp_data_o; winner's rsp_valid_o<=1; go RESP.
- RESP:
  - rsp_valid_o held and rsp_data_o stable until rsp_ready_i=1.
  - On handshake: rsp_valid_o<=0, ops_done_o<=ops_done_o+1 (wraps modulo 2^CNT_W), go IDLE.
  - The non-granted requester's rsp_valid_o stays 0 throughout; its rsp_data_o holds its last value.
- Latency: accept at cycle N -> rsp_valid_o high at N+2. If rsp_ready_i is already high, the response completes at N+2 and the next accept occurs at N+3. Minimum 3 cycles per operation.
- ALU op semantics, 32-bit, modulo 2^32:
  - 0 ADD a+b (carry dropped)
  - 1 SUB a-b (wraps)
  - 2 XOR
  - 3 LAND = {31'b0, (a!=0)&&(b!=0)}
  - 4 LOR = {31'b0, (a!=0)||(b!=0)}
  - 5 LNOT = {31'b0, a==0}
  - 6, 7 = 0 (accepted normally, not an error)
- Requester valid/operands need not be held once ready_o is seen; operand changes after acceptance have no effect.
- A requester whose valid drops before being granted simply loses its slot, with no side effects.
- Simultaneous: a new request arriving in EXEC/RESP is not accepted (ready_o=0) until IDLE.

Decomposition:
- Package cayde_alu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_XOR=2, OP_LAND=3, OP_LOR=4, OP_LNOT=5;
  - FSM state encoding ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - XLEN=32.
- One sub-module: the existing cayde_alu, instantiated once; the arbiter adds no arithmetic of its own.

Test Plan:
- Reset then req0 ADD a=32'hFFFF_FFFF, b=1, rsp_ready=1 -> req0_ready_o=1 at N, req0_rsp_valid_o=1 with data 32'h0 at N+2, ops_done_o=1 at N+3.
- Both valid simultaneously, PRIO_FIXED=0, req0 SUB 5-7, req1 XOR 32'hF0F0_F0F0^32'h0FF0_0FF0:
  - req0 served first with data 32'hFFFF_FFFE;
  - req1 accepted at next IDLE with data 32'hFF00_FF00;
  - grant_o sequence 0,1.
- Response backpressure: req1 LAND a=3, b=0 with rsp_ready_i=0 for 4 cycles -> rsp_valid_o held, data 0 stable, req0_ready_o=0 while busy; completes the cycle rsp_ready_i=1.
- PRIO_FIXED=1, both valid continuously for 3 transactions -> req0 granted each time; req1 never granted while req0 valid.
- rst_i asserted in RESP with a pending result -> next cycle rsp_valid_o=0, busy_o=0, ops_done_o=0, no response delivered; fresh req1 LNOT a=0 afterwards -> data 32'h1.
- Opcode 7 with a=b=32'h1234 -> accepted, response data 0; ops_done_o increments.
